fill_in_buffer: RTL and testbench

- 12-entry byte shift buffer feeding the edge-detection datapath with a window of the most recent pixel bytes read from memory.
- Bytes shift in on `shift_enable`.
- All 12 bytes are presented in parallel on `data_buffer`, with full/empty status flags.
- `buffer_clear` flushes the contents between windows/rows.

---
 rtl/fill_in_buffer.sv | 58 +++++
 tb/tb_fill_in_buffer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fill_in_buffer.sv
// Byte-wide shift window feeding the edge-detection datapath: newest byte at
// index 0, oldest at NUM_BYTES-1, with a saturating fill count behind the flags.
module fill_in_buffer #(
   parameter int NUM_BYTES  = 12,
   parameter int DATA_WIDTH = 8
) (
   input  logic                                   clk,
   input  logic                                   n_rst,
   input  logic                                   shift_enable,
   input  logic                                   buffer_clear,
   input  logic [DATA_WIDTH-1:0]                  read_data,
   output logic [NUM_BYTES-1:0][DATA_WIDTH-1:0]   data_buffer,
   output logic                                   buffer_full,
   output logic                                   buffer_empty
);

   localparam int CNT_W = $clog2(NUM_BYTES + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_BYTES);

   typedef logic [NUM_BYTES-1:0][DATA_WIDTH-1:0] window_t;

   window_t          data_q, data_d;
   logic [CNT_W-1:0] count_q, count_d;

   // Clear outranks shift so a row boundary never leaks a stray byte into the next window.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (latch).
      data_d  = data_q;
      count_d = count_q;
      if (buffer_clear) begin
         data_d  = '0;
         count_d = '0;
      end else if (shift_enable) begin
         data_d = {data_q[NUM_BYTES-2:0], read_data};
         if (count_q != CNT_MAX) begin
            count_d = count_q + CNT_W'(1);
         end
      end
   end

   // NOTE: the data array is reset explicitly because downstream logic reads all entries
   // in parallel and must see zeros, not X, before the window fills.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         data_q  <= '0;
         count_q <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         data_q  <= data_d;
         count_q <= count_d;
      end
   end

   assign data_buffer  = data_q;
   assign buffer_full  = (count_q == CNT_MAX);
   assign buffer_empty = (count_q == '0);

endmodule

// File: tb/tb_fill_in_buffer.sv
// Directed self-checking bench for fill_in_buffer: reset, fill, overflow slide,
// hold, clear, clear priority and asynchronous reset mid-fill.
module tb_fill_in_buffer;

   typedef logic [11:0][7:0] window_t;

   logic          clk;
   logic          n_rst;
   logic          shift_enable;
   logic          buffer_clear;
   logic [7:0]    read_data;
   window_t       data_buffer;
   logic          buffer_full;
   logic          buffer_empty;

   int total;
   int bad;

   logic [7:0] fill_bytes [12];

   fill_in_buffer #(.NUM_BYTES(12), .DATA_WIDTH(8)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .shift_enable (shift_enable),
      .buffer_clear (buffer_clear),
      .read_data    (read_data),
      .data_buffer  (data_buffer),
      .buffer_full  (buffer_full),
      .buffer_empty (buffer_empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs change and outputs are sampled here.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      n_rst        = 1'b1;
      shift_enable = 1'b0;
      buffer_clear = 1'b0;
      read_data    = 8'h00;
      #2;
      n_rst = 1'b0;
      #1;
      total++;
      if (data_buffer !== '0) begin
         bad++;
         $display("FAIL reset_data: got %h want %h", data_buffer, 96'h0);
      end
      total++;
      if (buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_flags: got empty=%b full=%b want empty=1 full=0", buffer_empty, buffer_full);
      end
      @(negedge clk);
      n_rst = 1'b1;
      tick();
      total++;
      if (data_buffer !== '0 || buffer_empty !== 1'b1) begin
         bad++;
         $display("FAIL reset_idle: got %h empty=%b want all 00 empty=1", data_buffer, buffer_empty);
      end
   endtask

   task automatic test_fill();
      window_t exp;
      shift_enable = 1'b1;
      for (int k = 0; k < 12; k++) begin
         read_data = fill_bytes[k];
         tick();
         total++;
         if (data_buffer[0] !== fill_bytes[k]) begin
            bad++;
            $display("FAIL fill_newest_%0d: got %h want %h", k, data_buffer[0], fill_bytes[k]);
         end
         total++;
         if (buffer_empty !== 1'b0 || buffer_full !== (k == 11)) begin
            bad++;
            $display("FAIL fill_flags_%0d: got empty=%b full=%b want empty=0 full=%b",
                     k, buffer_empty, buffer_full, (k == 11));
         end
      end
      for (int i = 0; i < 12; i++) exp[i] = fill_bytes[11-i];
      total++;
      if (data_buffer !== exp) begin
         bad++;
         $display("FAIL fill_window: got %h want %h", data_buffer, exp);
      end
      total++;
      if (data_buffer[11] !== 8'h2A) begin
         bad++;
         $display("FAIL fill_oldest: got %h want 2a", data_buffer[11]);
      end
   endtask

   task automatic test_overflow();
      read_data    = 8'h79;
      shift_enable = 1'b1;
      tick();
      total++;
      if (data_buffer[0] !== 8'h79 || data_buffer[1] !== 8'h9D || data_buffer[11] !== 8'h32) begin
         bad++;
         $display("FAIL overflow_slide: got [0]=%h [1]=%h [11]=%h want 79 9d 32",
                  data_buffer[0], data_buffer[1], data_buffer[11]);
      end
      total++;
      if (buffer_full !== 1'b1 || buffer_empty !== 1'b0) begin
         bad++;
         $display("FAIL overflow_flags: got full=%b empty=%b want full=1 empty=0", buffer_full, buffer_empty);
      end
      // A second overflow shift proves the count saturates rather than wrapping.
      read_data = 8'h11;
      tick();
      total++;
      if (buffer_full !== 1'b1 || data_buffer[0] !== 8'h11 || data_buffer[11] !== 8'h64) begin
         bad++;
         $display("FAIL overflow_saturate: got full=%b [0]=%h [11]=%h want full=1 11 64",
                  buffer_full, data_buffer[0], data_buffer[11]);
      end
   endtask

   task automatic test_hold();
      window_t exp;
      exp[0] = 8'h11;
      exp[1] = 8'h79;
      for (int i = 2; i < 12; i++) exp[i] = fill_bytes[13-i];
      shift_enable = 1'b0;
      read_data    = 8'h10;
      for (int n = 0; n < 2; n++) begin
         tick();
         total++;
         if (data_buffer !== exp || buffer_full !== 1'b1 || buffer_empty !== 1'b0) begin
            bad++;
            $display("FAIL hold_%0d: got %h full=%b empty=%b want %h full=1 empty=0",
                     n, data_buffer, buffer_full, buffer_empty, exp);
         end
      end
   endtask

   task automatic test_clear();
      buffer_clear = 1'b1;
      tick();
      total++;
      if (data_buffer !== '0 || buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin
         bad++;
         $display("FAIL clear: got %h empty=%b full=%b want all 00 empty=1 full=0",
                  data_buffer, buffer_empty, buffer_full);
      end
      // Clear while already empty, then release: state must stay cleared.
      tick();
      buffer_clear = 1'b0;
      tick();
      total++;
      if (data_buffer !== '0 || buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin
         bad++;
         $display("FAIL clear_hold: got %h empty=%b full=%b want all 00 empty=1 full=0",
                  data_buffer, buffer_empty, buffer_full);
      end
   endtask

   task automatic test_clear_priority();
      shift_enable = 1'b1;
      read_data    = 8'hC3;
      tick();
      read_data    = 8'h55;
      buffer_clear = 1'b1;
      tick();
      buffer_clear = 1'b0;
      total++;
      if (data_buffer !== '0 || buffer_empty !== 1'b1) begin
         bad++;
         $display("FAIL clear_priority: got %h empty=%b want all 00 empty=1", data_buffer, buffer_empty);
      end
      // Count must restart at 0: full only on exactly the 12th shift after the clear.
      for (int k = 0; k < 12; k++) begin
         read_data = 8'hA0 + 8'(k);
         tick();
         total++;
         if (buffer_full !== (k == 11)) begin
            bad++;
            $display("FAIL clear_count_%0d: got full=%b want %b", k, buffer_full, (k == 11));
         end
      end
      total++;
      if (data_buffer[0] !== 8'hAB || data_buffer[11] !== 8'hA0) begin
         bad++;
         $display("FAIL clear_refill: got [0]=%h [11]=%h want ab a0", data_buffer[0], data_buffer[11]);
      end
      shift_enable = 1'b0;
   endtask

   task automatic test_reset_midfill();
      shift_enable = 1'b1;
      read_data    = 8'h5A;
      tick();
      tick();
      shift_enable = 1'b0;
      #2;
      n_rst = 1'b0;
      #1;
      total++;
      if (data_buffer !== '0 || buffer_empty !== 1'b1 || buffer_full !== 1'b0) begin
         bad++;
         $display("FAIL reset_midfill: got %h empty=%b full=%b want all 00 empty=1 full=0",
                  data_buffer, buffer_empty, buffer_full);
      end
      @(negedge clk);
      n_rst = 1'b1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      fill_bytes = '{8'h2A, 8'h32, 8'h64, 8'h85, 8'h45, 8'hE1,
                     8'h76, 8'h40, 8'h23, 8'hA8, 8'h4F, 8'h9D};
      test_reset();
      test_fill();
      test_overflow();
      test_hold();
      test_clear();
      test_clear_priority();
      test_reset_midfill();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
